// File: rtl/irq_pend8.sv
// Sticky interrupt-pending collector with per-source mask and overflow flags.
// Define IRQ_SYNC_EN to pass req through a 2-flop synchronizer before event detection.
module irq_pend8 #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_wdata,
    input  logic             ack,
    input  logic [2:0]       ack_idx,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] pend_raw,
    output logic [WIDTH-1:0] pend_out,
    output logic             irq,
    output logic [WIDTH-1:0] ovf
);

    logic [WIDTH-1:0] req_in;
    logic [WIDTH-1:0] s_q, s_hist_q;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] ack_vec;

`ifdef IRQ_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    assign req_in = sync2_q;
`else
    assign req_in = req;
`endif

    // History resets to 0, so a request already high after reset is seen as a rising edge.
    assign ev      = EDGE_MODE ? (s_q & ~s_hist_q) : s_q;
    assign ack_vec = ack ? (WIDTH'(1) << ack_idx) : '0;

    always_comb begin
        pend_d = (pend_q & ~ack_vec) | ev;
        ovf_d  = (ovf_clr ? '0 : ovf_q) | (ev & pend_q & ~ack_vec);
        mask_d = mask_we ? mask_wdata : mask_q;
        irq_d  = |(pend_d & mask_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            s_hist_q <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            ovf_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            s_q      <= req_in;
            s_hist_q <= s_q;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign pend_raw = pend_q;
    assign pend_out = pend_q & mask_q;
    assign irq      = irq_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_pend8.sv
// Directed bench for irq_pend8: capture latency, ack, overflow, masking and async reset.
module tb_irq_pend8;

`ifdef IRQ_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] pend_raw, pend_out, ovf;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    irq_pend8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .ovf_clr    (ovf_clr),
        .pend_raw   (pend_raw),
        .pend_out   (pend_out),
        .irq        (irq),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference highest-index-wins encoder downstream of pend_out.
    function automatic logic [7:0] enc(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return 8'(i);
        return 8'h00;
    endfunction

    task automatic do_ack(input logic [2:0] idx);
        ack = 1'b1; ack_idx = idx;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_we = 1'b1; mask_wdata = m;
        tick(1);
        mask_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
        ack = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
        #12;
        chk("rst_pend_raw", pend_raw, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_ovf", ovf, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        set_mask(8'hFF);
        chk("mask_no_pend", pend_out, 8'h00);

        // Capture latency for 8'h24
        req = 8'h24;
        tick(Lat - 1);
        chk("lat_not_yet", pend_raw, 8'h00);
        tick(1);
        chk("cap_pend_out", pend_out, 8'h24);
        chk("cap_irq", {7'd0, irq}, 8'h01);
        chk("cap_enc", enc(pend_out), 8'd5);

        do_ack(3'd5);
        chk("ack5_pend_out", pend_out, 8'h04);
        chk("ack5_irq", {7'd0, irq}, 8'h01);
        do_ack(3'd2);
        chk("ack2_pend_out", pend_out, 8'h00);
        chk("ack2_irq", {7'd0, irq}, 8'h00);
        do_ack(3'd6);
        chk("ack_nopend", pend_raw, 8'h00);
        chk("held_no_ovf", ovf, 8'h00);

        // Set wins over simultaneous ack of the same bit, no overflow
        req = 8'h00; tick(Lat);
        req = 8'h08; tick(Lat);
        chk("bit3_pend", pend_raw, 8'h08);
        req = 8'h00; tick(Lat);
        req = 8'h08; tick(Lat - 1);
        do_ack(3'd3);
        chk("set_wins_pend", pend_raw, 8'h08);
        chk("set_wins_ovf", ovf, 8'h00);
        do_ack(3'd3);
        chk("bit3_cleared", pend_raw, 8'h00);

        // Overflow on bit 0
        req = 8'h00; tick(Lat);
        req = 8'h01; tick(Lat);
        req = 8'h00; tick(Lat);
        req = 8'h01; tick(Lat);
        chk("ovf_set", ovf, 8'h01);
        chk("ovf_pend", pend_raw, 8'h01);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 8'h00);
        chk("ovf_clr_pend", pend_raw, 8'h01);
        req = 8'h00; tick(Lat);
        req = 8'h01; tick(Lat - 1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("ovf_beats_clr", ovf, 8'h01);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        do_ack(3'd0);
        chk("bit0_cleared", pend_raw, 8'h00);
        chk("ovf_cleared2", ovf, 8'h00);

        // Masking hides but keeps pending
        req = 8'h00; tick(Lat);
        set_mask(8'h0F);
        req = 8'h80; tick(Lat);
        chk("masked_raw", pend_raw, 8'h80);
        chk("masked_out", pend_out, 8'h00);
        chk("masked_irq", {7'd0, irq}, 8'h00);
        set_mask(8'hFF);
        chk("unmask_out", pend_out, 8'h80);
        chk("unmask_irq", {7'd0, irq}, 8'h01);

        // Async reset mid-operation, req held high through release
        req = 8'h00; tick(Lat);
        req = 8'hFF; tick(Lat);
        chk("all_pend", pend_raw, 8'hFF);
        chk("ovf7", ovf, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pend_raw", pend_raw, 8'h00);
        chk("async_pend_out", pend_out, 8'h00);
        chk("async_irq", {7'd0, irq}, 8'h00);
        chk("async_ovf", ovf, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick(Lat);
        chk("rel_capture", pend_raw, 8'hFF);
        chk("rel_masked", pend_out, 8'h00);
        do_ack(3'd0);
        chk("rel_ack0", pend_raw, 8'hFE);
        tick(3);
        chk("rel_once", pend_raw, 8'hFE);
        chk("rel_no_ovf", ovf, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
